// File: rtl/cell_exit_collector_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cell_exit_collector_if : cell-array and exit-stream handshake bundle       |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface cell_exit_collector_if #(
  parameter int N_CELL = 27,
  parameter int ELEM_W = 97,
  parameter int CID_W  = $clog2(N_CELL)
);
  logic [N_CELL-1:0]        i_cell_valid;
  logic [N_CELL*ELEM_W-1:0] i_cell_data;
  logic [N_CELL-1:0]        o_cell_ack;
  logic                     o_tvalid;
  logic [ELEM_W-1:0]        o_tdata;
  logic [CID_W-1:0]         o_tcell;
  logic                     i_tready;

  modport slave (
    input  i_cell_valid, i_cell_data, i_tready,
    output o_cell_ack, o_tvalid, o_tdata, o_tcell
  );

  modport master (
    output i_cell_valid, i_cell_data, i_tready,
    input  o_cell_ack, o_tvalid, o_tdata, o_tcell
  );
endinterface
`default_nettype wire

// File: rtl/cell_exit_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cell_exit_collector : round-robin LANES-wide cell scan into a multi-write  |
// | FWFT FIFO. Macro EXIT_SKIP_IDLE_EN: scan skips groups with no valid lane.  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module cell_exit_collector #(
  parameter int N_CELL     = 27,
  parameter int ELEM_W     = 97,
  parameter int LANES      = 2,
  parameter int FIFO_DEPTH = 64,
  parameter int CID_W      = $clog2(N_CELL),
  parameter int OCC_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_flush,
  cell_exit_collector_if.slave    bus,
  output logic [OCC_W-1:0]        o_occupancy,
  output logic [31:0]             o_pop_count,
  output logic                    o_idle
);
  localparam int c_NGROUP = (N_CELL + LANES - 1) / LANES;
  localparam int c_NLANE  = c_NGROUP * LANES;
  localparam int c_PTR_W  = (c_NGROUP > 1) ? $clog2(c_NGROUP) : 1;
  localparam int c_IDX_W  = (c_NLANE > 1) ? $clog2(c_NLANE) : 1;
  localparam int c_AW     = $clog2(FIFO_DEPTH);
  localparam int c_ENT_W  = CID_W + ELEM_W;
  localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(c_NGROUP - 1);

  logic [c_NLANE-1:0]  w_valid_pad;
  logic [ELEM_W-1:0]   w_data_arr [c_NLANE];
  logic [c_NGROUP-1:0] w_grp_any;
  logic [c_PTR_W-1:0]  w_sel;
  logic [c_PTR_W-1:0]  w_ptr_nxt;
  logic                w_adv;
  logic                w_space_ok;
  logic                w_accept;
  logic [LANES-1:0]    w_lane_v;
  logic [c_ENT_W-1:0]  w_lane_ent [LANES];
  logic [c_AW-1:0]     w_wr_addr  [LANES];
  logic [c_AW-1:0]     w_push_cnt;
  logic [N_CELL-1:0]   w_ack;
  logic                w_tvalid;
  logic                w_pop;
  logic [c_ENT_W-1:0]  w_head;

  logic [c_PTR_W-1:0]  r_ptr;
  logic [c_AW-1:0]     r_wr;
  logic [c_AW-1:0]     r_rd;
  logic [OCC_W-1:0]    r_occ;
  logic [31:0]         r_pop_count;
  logic [c_ENT_W-1:0]  r_mem [FIFO_DEPTH];

  // Pad the cell vector to a whole number of groups; pad lanes never present.
  for (genvar c = 0; c < c_NLANE; c++) begin : g_lane_map
    if (c < N_CELL) begin : g_real
      assign w_valid_pad[c] = bus.i_cell_valid[c];
      assign w_data_arr[c]  = bus.i_cell_data[c*ELEM_W +: ELEM_W];
    end else begin : g_pad
      assign w_valid_pad[c] = 1'b0;
      assign w_data_arr[c]  = '0;
    end
  end

  always_comb begin
    w_grp_any = '0;
    for (int g = 0; g < c_NGROUP; g++)
      w_grp_any[g] = |w_valid_pad[g*LANES +: LANES];
  end

`ifdef EXIT_SKIP_IDLE_EN
  logic               v_found;
  int                 v_idx;
  logic [c_PTR_W-1:0] v_cand;

  always_comb begin
    v_found = 1'b0;
    v_idx   = 0;
    v_cand  = '0;
    w_sel   = r_ptr;
    for (int k = 0; k < c_NGROUP; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= c_NGROUP) v_idx = v_idx - c_NGROUP;
      v_cand = c_PTR_W'(v_idx);
      if (!v_found && w_grp_any[v_cand]) begin
        v_found = 1'b1;
        w_sel   = v_cand;
      end
    end
  end

  assign w_adv = w_accept;
`else
  assign w_sel = r_ptr;
  assign w_adv = w_accept || !w_grp_any[w_sel];
`endif

  // Space is judged on the start-of-cycle fill; a same-cycle pop earns nothing.
  assign w_space_ok = (r_occ <= OCC_W'(FIFO_DEPTH - LANES));
  assign w_accept   = w_grp_any[w_sel] && w_space_ok && !i_flush;

  always_comb begin
    logic [c_AW-1:0]    v_ord;
    logic [c_IDX_W-1:0] v_cell;
    v_ord  = '0;
    v_cell = '0;
    for (int l = 0; l < LANES; l++) begin
      v_cell        = c_IDX_W'(int'(w_sel) * LANES + l);
      w_lane_v[l]   = w_valid_pad[v_cell];
      w_lane_ent[l] = {CID_W'(v_cell), w_data_arr[v_cell]};
      w_wr_addr[l]  = r_wr + v_ord;
      if (w_lane_v[l]) v_ord = v_ord + c_AW'(1);
    end
    w_push_cnt = w_accept ? v_ord : '0;
  end

  always_comb begin
    w_ack = '0;
    for (int c = 0; c < N_CELL; c++)
      if (w_accept && ((c / LANES) == int'(w_sel)))
        w_ack[c] = bus.i_cell_valid[c];
  end

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (i_flush)
      w_ptr_nxt = '0;
    else if (w_adv)
      w_ptr_nxt = (w_sel == c_LAST) ? '0 : w_sel + c_PTR_W'(1);
  end

  assign w_tvalid = (r_occ != '0);
  assign w_pop    = w_tvalid && bus.i_tready && !i_flush;
  assign w_head   = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_occ       <= '0;
      r_pop_count <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_pop) r_pop_count <= r_pop_count + 32'd1;
      if (i_flush) begin
        r_wr  <= '0;
        r_rd  <= '0;
        r_occ <= '0;
      end else begin
        r_wr  <= r_wr + w_push_cnt;
        r_rd  <= r_rd + c_AW'(w_pop);
        r_occ <= r_occ + {1'b0, w_push_cnt} - OCC_W'(w_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++)
      if (w_accept && w_lane_v[l]) r_mem[w_wr_addr[l]] <= w_lane_ent[l];
  end

  assign bus.o_cell_ack = w_ack;
  assign bus.o_tvalid   = w_tvalid;
  assign bus.o_tdata    = w_tvalid ? w_head[ELEM_W-1:0] : '0;
  assign bus.o_tcell    = w_tvalid ? w_head[c_ENT_W-1 -: CID_W] : '0;
  assign o_occupancy    = r_occ;
  assign o_pop_count    = r_pop_count;
  assign o_idle         = (r_occ == '0) && (bus.i_cell_valid == '0);
endmodule
`default_nettype wire

// File: doc/cell_exit_collector.md
# cell_exit_collector

Parametrised round-robin collector that gathers exiting particle records from the N_CELL cell pipelines, LANES cells per cycle, and buffers them in a multi-write FIFO for the dump/k2h path. Each FIFO entry carries its source cell index. Cells are back-pressured with a per-cell acknowledge. The block replaces the fixed pair-slot scan feeding the exit FIFO and sits between the cell array and the dump stream formatter.

## Interface
- N_CELL, 27, number of cell sources
- ELEM_W, 97, width of one particle record
- LANES, 2, cells inspected and maximum FIFO writes per cycle (1..8)
- FIFO_DEPTH, 64, entries; power of two, at least 2*LANES
- CID_W, $clog2(N_CELL), source cell index width
- OCC_W, $clog2(FIFO_DEPTH)+1, occupancy width
---
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_flush  in  1  synchronous clear of the FIFO and scan pointer; counters are kept
- i_cell_valid  in  N_CELL  cell c presents a record
- i_cell_data  in  N_CELL*ELEM_W  record of cell c at bits [c*ELEM_W +: ELEM_W]
- o_cell_ack  out  N_CELL  record of cell c is taken this cycle (combinational)
- o_tvalid  out  1  output entry valid
- o_tdata  out  ELEM_W  output record
- o_tcell  out  CID_W  source cell of o_tdata
- i_tready  in  1  consumer accepts the entry
- o_occupancy  out  OCC_W  current FIFO fill
- o_pop_count  out  32  records popped since reset; wraps modulo 2^32
- o_idle  out  1  FIFO empty and i_cell_valid == 0

## Operation
- Groups: NGROUP = ceil(N_CELL/LANES). Group g covers cells g*LANES .. g*LANES+LANES-1. Lanes with index >= N_CELL are tied invalid.
- Scan pointer ptr, range 0..NGROUP-1, wraps from NGROUP-1 to 0.
- Accept condition: group ptr has at least one valid lane, and (FIFO_DEPTH − occupancy) >= LANES. Occupancy is the registered value at the start of the cycle; a same-cycle pop is not credited.
- On accept:
  - o_cell_ack[c] = i_cell_valid[c] for every cell c in the group.
  - Valid lanes are compacted in ascending lane order and written as consecutive FIFO entries {cell index, record}.
  - ptr advances.
- Stall: the group has a valid lane but there is insufficient space. No ack, ptr holds.
- Empty group: no write, no ack, ptr advances.
- o_cell_ack is 0 for every cell outside the current group and whenever not accepting.
- Pop: a pop occurs when o_tvalid && i_tready. The FIFO is first-word-fall-through. o_pop_count increments on each pop.
- Push and pop in the same cycle are legal. Occupancy updates by pushes minus pops.
- i_flush:
  - Empties the FIFO and sets ptr to 0.
  - Forces o_cell_ack to 0 that cycle.
  - Takes priority over push and pop in the same cycle.
  - o_pop_count is not cleared.

## Timing
- Reset values: ptr 0, occupancy 0, o_tvalid 0, o_tdata 0, o_tcell 0, o_pop_count 0, o_cell_ack 0, o_idle 1 (given no valid inputs).
- Latency: a record acked in cycle t is presented on o_tdata in cycle t+1 at the earliest, when the FIFO was empty.
- o_tdata and o_tcell are held stable while o_tvalid && !i_tready.
- Throughput: up to LANES writes per cycle and 1 read per cycle.
- Reset asserted mid-operation discards all FIFO contents at the next edge. A record acked in the reset cycle is lost, and that is acceptable.
- Acks depend combinationally on i_cell_valid, ptr and occupancy only, never on i_tready.

## Configuration
- EXIT_SKIP_IDLE_EN
  - Defined: in each cycle ptr selects the first group, searching round-robin from the current ptr inclusive, that has a valid lane. After an accept, ptr moves to the group after the selected one. When no group has a valid lane, ptr holds.
  - Undefined: ptr visits groups strictly in sequence, one group per cycle.

## Test plan
- Reset, then all 27 cells valid, i_tready=1:
  - 27 records emerge in cell order 0..26.
  - Without the macro: one group per cycle, complete by cycle 15.
  - Final state: o_pop_count=27, o_idle=1.
- Only cell 26 valid (last group, lane 1 padded):
  - It is acked once with a single write and o_tcell=26.
  - With EXIT_SKIP_IDLE_EN it is acked in the first cycle after reset.
- i_tready=0, all cells valid continuously, FIFO_DEPTH=64, LANES=2:
  - Occupancy reaches 63 or 64, then acks stop.
  - One pop at occupancy 63 does not allow an accept in that same cycle; the accept occurs in the next cycle.
- Simultaneous push of 2 and pop of 1 at occupancy 10 → occupancy 11. The popped record is the oldest entry.
- Assert i_flush with occupancy 20:
  - Next cycle: occupancy 0, o_tvalid 0, ptr 0.
  - o_pop_count is unchanged.
  - No ack in the flush cycle.
- Hold i_tready=0 for 5 cycles with o_tvalid=1 → o_tdata and o_tcell stay constant, then advance one entry per cycle once i_tready=1.
